rom_channel_arbiter: RTL and testbench

ROM_CHANNEL_ARBITER -- requirements
Module: rom_channel_arbiter

---
 rtl/rom_channel_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_rom_channel_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_channel_arbiter.sv
`timescale 1ns/1ps
// rom_channel_arbiter
// Shares one slow external EPROM among NUM_CH client channels. Each channel
// keeps a one-entry cache (tag, tag_valid, data). A channel that is enabled and
// misses its cache requests an external access. Requests are served round-robin,
// one access of WAIT_CYCLES cycles at a time.
//
// Ports
//   clk_48m   in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ch_ce_n   in   [NUM_CH]         per-channel chip enable (active-low)
//   ch_oe_n   in   [NUM_CH]         per-channel output enable (active-low)
//   ch_addr   in   [NUM_CH*ADDR_W]  packed channel addresses
//   ch_data   out  [NUM_CH*DATA_W]  packed cached read data (registered)
//   ch_valid  out  [NUM_CH]         ch_data[i] matches the current ch_addr[i]
//   ext_addr  out  [CH_W+ADDR_W]    {channel index, channel address}
//   ext_cs_n  out  external chip select (active-low, registered)
//   ext_oe_n  out  external output enable (active-low, registered)
//   ext_data  in   [DATA_W]         external read data
//   busy      out  high while an external access is in progress
module rom_channel_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 3,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_48m,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_ce_n,
  input  logic [NUM_CH-1:0]        ch_oe_n,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [CH_W+ADDR_W-1:0]   ext_addr,
  output logic                     ext_cs_n,
  output logic                     ext_oe_n,
  input  logic [DATA_W-1:0]        ext_data,
  output logic                     busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic                       busy_r;
  logic [CH_W-1:0]            grant_r;
  logic [CH_W-1:0]            last_r;
  logic [3:0]                 cnt_r;
  logic [ADDR_W-1:0]          tag_r [NUM_CH];
  logic [NUM_CH-1:0]          tag_valid_r;
  logic [NUM_CH*DATA_W-1:0]   data_r;
  logic [CH_W+ADDR_W-1:0]     ext_addr_r;
  logic                       ext_cs_n_r;
  logic                       ext_oe_n_r;

  logic [NUM_CH-1:0]          hit_s;
  logic [NUM_CH-1:0]          req_s;
  logic                       pick_vld_s;
  logic [CH_W-1:0]            pick_s;
  logic [CH_W-1:0]            idx_s;
  logic [ADDR_W-1:0]          pick_addr_s;

  assign ch_data  = data_r;
  assign ext_addr = ext_addr_r;
  assign ext_cs_n = ext_cs_n_r;
  assign ext_oe_n = ext_oe_n_r;
  assign busy     = busy_r;

  // Cache hit, request and valid decode per channel.
  always_comb begin
    hit_s    = '0;
    req_s    = '0;
    ch_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit_s[i]    = tag_valid_r[i] & (ch_addr[i*ADDR_W +: ADDR_W] == tag_r[i]);
      req_s[i]    = ~ch_ce_n[i] & ~ch_oe_n[i] & ~hit_s[i];
      // The channel being refilled never shows valid while its access runs.
      ch_valid[i] = hit_s[i] & ~(busy_r & (grant_r == CH_W'(i)));
    end
  end

  // Round-robin pick: first requester after the last granted channel, wrapping.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = '0;
    idx_s      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx_s = CH_W'((int'(last_r) + k) % NUM_CH);
      if (!pick_vld_s && req_s[idx_s]) begin
        pick_vld_s = 1'b1;
        pick_s     = idx_s;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
    pick_addr_s = ch_addr[int'(pick_s)*ADDR_W +: ADDR_W];
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and busy flag.
  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_ACCESS);
    end
  end

  // Grant bookkeeping, external bus drive, wait counter and cache update.
  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) begin
      grant_r     <= '0;
      last_r      <= CH_W'(NUM_CH - 1);
      cnt_r       <= 4'd0;
      tag_valid_r <= '0;
      data_r      <= '1;
      ext_addr_r  <= '0;
      ext_cs_n_r  <= 1'b1;
      ext_oe_n_r  <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_vld_s) begin
            grant_r        <= pick_s;
            last_r         <= pick_s;
            tag_r[pick_s]  <= pick_addr_s;
            ext_addr_r     <= {pick_s, pick_addr_s};
            cnt_r          <= CNT_LOAD;
            ext_cs_n_r     <= 1'b0;
            ext_oe_n_r     <= 1'b0;
          end else begin
            ext_cs_n_r <= 1'b1;
            ext_oe_n_r <= 1'b1;
          end
        end
        ST_ACCESS: begin
          // ext_data is only trusted on the final access edge.
          if (cnt_r == 4'd0) begin
            data_r[int'(grant_r)*DATA_W +: DATA_W] <= ext_data;
            tag_valid_r[grant_r]                   <= 1'b1;
            ext_cs_n_r                             <= 1'b1;
            ext_oe_n_r                             <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          ext_cs_n_r <= 1'b1;
          ext_oe_n_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_channel_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for rom_channel_arbiter (NUM_CH=4, ADDR_W=15, DATA_W=8,
// WAIT_CYCLES=3). A transaction-level reference model predicts each external
// access and the per-channel cache contents; a monitor compares the DUT to it.
module tb_rom_channel_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int WAIT   = 3;
  localparam int AW     = 17;

  logic                     clk_48m;
  logic                     rst_n;
  logic [NUM_CH-1:0]        ch_ce_n;
  logic [NUM_CH-1:0]        ch_oe_n;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [AW-1:0]            ext_addr;
  logic                     ext_cs_n;
  logic                     ext_oe_n;
  logic [DATA_W-1:0]        ext_data;
  logic                     busy;

  rom_channel_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT)
  ) dut (
    .clk_48m (clk_48m),
    .rst_n   (rst_n),
    .ch_ce_n (ch_ce_n),
    .ch_oe_n (ch_oe_n),
    .ch_addr (ch_addr),
    .ch_data (ch_data),
    .ch_valid(ch_valid),
    .ext_addr(ext_addr),
    .ext_cs_n(ext_cs_n),
    .ext_oe_n(ext_oe_n),
    .ext_data(ext_data),
    .busy    (busy)
  );

  initial begin
    clk_48m = 1'b0;
    forever #5 clk_48m = ~clk_48m;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Contents of the external EPROM image.
  function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ {a[16:15], 6'h2b};
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return ch_addr[i*ADDR_W +: ADDR_W];
  endfunction

  // External memory: real data only on the last cycle of an access, noise otherwise.
  int mcount;
  initial begin
    ext_data = 8'h00;
    mcount   = 0;
    forever begin
      @(posedge clk_48m);
      #1;
      if (!ext_cs_n) mcount++;
      else mcount = 0;
      ext_data = (mcount == WAIT) ? mem_val(ext_addr) : 8'($urandom);
    end
  end

  // ---------------- reference model ----------------
  logic [ADDR_W-1:0] m_tag  [NUM_CH];
  bit                m_tv   [NUM_CH];
  logic [7:0]        m_data [NUM_CH];
  int                m_last, m_g, m_left;
  bit                m_acc;
  logic [AW-1:0]     exp_q[$];
  logic [AW-1:0]     log_q[$];

  task automatic model_reset();
    m_last = NUM_CH - 1;
    m_acc  = 1'b0;
    m_left = 0;
    m_g    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_tag[i]  = '0;
      m_tv[i]   = 1'b0;
      m_data[i] = 8'hFF;
    end
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_48m);
      if (!rst_n) begin
        model_reset();
      end else if (m_acc) begin
        m_left--;
        if (m_left == 0) begin
          m_data[m_g] = mem_val({2'(m_g), m_tag[m_g]});
          m_tv[m_g]   = 1'b1;
          m_acc       = 1'b0;
        end
      end else begin
        for (int k = 1; k <= NUM_CH; k++) begin
          int c;
          c = (m_last + k) % NUM_CH;
          if (!m_acc && !ch_ce_n[c] && !ch_oe_n[c] && !(m_tv[c] && addr_of(c) == m_tag[c])) begin
            m_g      = c;
            m_tag[c] = addr_of(c);
            m_last   = c;
            m_acc    = 1'b1;
            m_left   = WAIT;
            exp_q.push_back({2'(c), addr_of(c)});
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit prev_cs;
  int cs_len;
  initial begin
    logic [NUM_CH-1:0]        exp_v;
    logic [NUM_CH*DATA_W-1:0] exp_d;
    prev_cs = 1'b1;
    cs_len  = 0;
    forever begin
      @(negedge clk_48m);
      if (!rst_n) begin
        prev_cs = 1'b1;
        cs_len  = 0;
      end else begin
        if (prev_cs && !ext_cs_n) begin
          check("access_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) check("ext_addr", 64'(ext_addr), 64'(exp_q.pop_front()));
          log_q.push_back(ext_addr);
        end
        if (!ext_cs_n) cs_len++;
        if (!prev_cs && ext_cs_n) begin
          check("cs_low_cycles", 64'(cs_len), 64'(WAIT));
          cs_len = 0;
        end
        exp_v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          exp_v[i] = m_tv[i] && (addr_of(i) == m_tag[i]) && !(m_acc && m_g == i);
          exp_d[i*DATA_W +: DATA_W] = m_data[i];
        end
        check("busy", 64'(busy), 64'(m_acc));
        check("ext_cs_n", 64'(ext_cs_n), 64'(!m_acc));
        check("ext_oe_n", 64'(ext_oe_n), 64'(!m_acc));
        check("ch_valid", 64'(ch_valid), 64'(exp_v));
        check("ch_data", 64'(ch_data), 64'(exp_d));
        prev_cs = ext_cs_n;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk_48m);
      #1;
    end
  endtask

  task automatic set_ch(input int i, input bit en, input logic [ADDR_W-1:0] a);
    ch_ce_n[i] = !en;
    ch_oe_n[i] = !en;
    ch_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  // Asserts reset between edges, checks the immediate reset state, then releases.
  task automatic do_reset();
    @(posedge clk_48m);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_ext_cs_n", 64'(ext_cs_n), 64'd1);
    check("rst_ext_oe_n", 64'(ext_oe_n), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ext_addr", 64'(ext_addr), 64'd0);
    check("rst_ch_valid", 64'(ch_valid), 64'd0);
    check("rst_ch_data", 64'(ch_data), 64'hFFFF_FFFF);
    @(posedge clk_48m);
    @(posedge clk_48m);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy && n < 10) begin
      @(posedge clk_48m);
      #1;
      n++;
    end
    check("wait_busy", 64'(busy), 64'd1);
  endtask

  function automatic logic [AW-1:0] log_at(input int i);
    return (log_q.size() > i) ? log_q[i] : 17'bx;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scenarios ----------------
  initial begin
    logic [ADDR_W-1:0] a1, a3;
    rst_n   = 1'b0;
    ch_ce_n = '1;
    ch_oe_n = '1;
    ch_addr = '0;

    // Single channel fill, then no re-access while the address is stable.
    do_reset();
    log_q.delete();
    set_ch(0, 1'b1, 15'h1234);
    run(16);
    check("s1_ext_addr", 64'(log_at(0)), 64'h01234);
    check("s1_access_count", 64'(log_q.size()), 64'd1);
    check("s1_ch_valid0", 64'(ch_valid[0]), 64'd1);
    check("s1_ch_data0", 64'(ch_data[7:0]), 64'(mem_val(17'h01234)));

    // All four channels at once: grants 0,1,2,3.
    do_reset();
    log_q.delete();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 15'(16'h0100 + i));
    run(20);
    check("s2_access_count", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < NUM_CH; i++) check("s2_grant_order", 64'(log_at(i) >> ADDR_W), 64'(i));
    ch_ce_n = '1;
    ch_oe_n = '1;

    // Address change mid-access: stale capture, then re-served.
    do_reset();
    log_q.delete();
    set_ch(2, 1'b1, 15'h0010);
    wait_busy();
    run(1);
    set_ch(2, 1'b1, 15'h0020);
    run(14);
    check("s3_first_addr", 64'(log_at(0)), 64'h10010);
    check("s3_second_addr", 64'(log_at(1)), 64'h10020);
    check("s3_ch_valid2", 64'(ch_valid[2]), 64'd1);
    ch_ce_n = '1;
    ch_oe_n = '1;

    // Reset in cycle 2 of an access; afterwards channel 0 wins again.
    do_reset();
    set_ch(0, 1'b1, 15'h0055);
    set_ch(1, 1'b1, 15'h0066);
    wait_busy();
    do_reset();
    log_q.delete();
    run(12);
    check("s4_regrant_ch0", 64'(log_at(0)), 64'h00055);
    check("s4_then_ch1", 64'(log_at(1)), 64'h08066);
    ch_ce_n = '1;
    ch_oe_n = '1;

    // Two continuous requesters after ch1 served last: 3,1,3,1.
    do_reset();
    a1 = 15'h0200;
    a3 = 15'h0300;
    set_ch(1, 1'b1, a1);
    run(8);
    log_q.delete();
    for (int n = 0; n < 24; n++) begin
      a1++;
      a3++;
      set_ch(1, 1'b1, a1);
      set_ch(3, 1'b1, a3);
      run(1);
    end
    check("s5_grant0", 64'(log_at(0) >> ADDR_W), 64'd3);
    check("s5_grant1", 64'(log_at(1) >> ADDR_W), 64'd1);
    check("s5_grant2", 64'(log_at(2) >> ADDR_W), 64'd3);
    check("s5_grant3", 64'(log_at(3) >> ADDR_W), 64'd1);
    ch_ce_n = '1;
    ch_oe_n = '1;

    // Deselect during access: capture completes, no new request.
    do_reset();
    log_q.delete();
    set_ch(0, 1'b1, 15'h0077);
    wait_busy();
    ch_ce_n[0] = 1'b1;
    run(10);
    check("s6_ch_data0", 64'(ch_data[7:0]), 64'(mem_val(17'h00077)));
    check("s6_access_count", 64'(log_q.size()), 64'd1);
    check("s6_ch_valid0", 64'(ch_valid[0]), 64'd1);

    // Random traffic over a small address set so hits and misses mix.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) begin
        int c;
        c = $urandom_range(NUM_CH - 1);
        ch_ce_n[c] = ($urandom_range(3) == 0);
        ch_oe_n[c] = ($urandom_range(3) == 0);
        ch_addr[c*ADDR_W +: ADDR_W] = 15'($urandom_range(3)) + 15'h0040;
      end
      run(1);
    end

    // Drain.
    ch_ce_n = '1;
    ch_oe_n = '1;
    run(8);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
